ascon_perm_core: RTL and testbench
==================================

Name: ascon_perm_core

Overview:
- Iterative, parametrised ASCON permutation engine. Generalises the single-round combinational layer into a multi-round sequential core.
- Per-round operations: round-constant addition, 5-bit S-box, linear diffusion.
- Round count is selectable per transaction (p^a / p^b). Hardware unroll factor is a parameter.
- Sits between the mode controller (init/absorb/squeeze/final) and the 320-bit state register, with valid/ready handshakes on both sides.

Parameters:
- UNROLL, 1, rounds computed per clock cycle. Legal values: 1, 2, 3.
- DEFAULT_ROUNDS, 12, round count used when in_rounds is illegal.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  source presents a state to permute
- in_ready  out  1  core can accept a state
- in_state  in  320  {x0,x1,x2,x3,x4}; x0 = [319:256], x4 = [63:0]
- in_rounds  in  4  number of rounds R for this transaction; sampled on accept
- out_valid  out  1  permuted state available
- out_ready  in  1  sink accepts the result
- out_state  out  320  permuted state, same word ordering as in_state
- out_err  out  1  the transaction used an illegal in_rounds; DEFAULT_ROUNDS was applied
- busy  out  1  asserted in RUN

Behaviour:
- Reset: asynchronous, active-high. While rst=1 and on release:
  - FSM = IDLE; in_ready=1; out_valid=0; out_err=0; busy=0; out_state=0; round index=0.
- Round function for round index i (0..11):
  - Constant c_i = {(4'hF - i), i[3:0]}, i.e. 0xF0, 0xE1, ... 0x4B. XOR c_i into x2[7:0].
  - S-box, bit-sliced per column: t=x0^x4, u=x1^x2, v=x3^x4, then chi step, then the output XOR/complement network. Column value 0x00 maps to 0x04; 0x04 maps to 0x1A (x0 is the MSB of the column).
  - Linear layer, right rotations: x0: 19,28; x1: 61,39; x2: 1,6; x3: 10,17; x4: 7,41. Each xj' = xj ^ rot_a(xj) ^ rot_b(xj).
- Round selection:
  - R rounds use indices 12-R .. 11, in order.
  - in_rounds is legal iff 1 <= R <= 12 and R mod UNROLL == 0.
  - Otherwise R = DEFAULT_ROUNDS and out_err is set for that result.
- FSM:
  - IDLE: in_ready=1. When in_valid & in_ready: load state, i <= 12-R, go to RUN.
  - RUN: in_ready=0, busy=1. Each cycle apply UNROLL chained rounds and set i <= i+UNROLL. When the last index (11) has been applied, register the result into out_state, set out_valid=1, go to DONE.
  - DONE: out_valid=1; out_state and out_err held stable. When out_ready=1: out_valid <= 0 and go to IDLE.
- Latency: accept edge to out_valid = R/UNROLL cycles. Example: R=12, UNROLL=1 gives 12 cycles.
- Throughput: one accept per R/UNROLL + 2 cycles minimum (IDLE and DONE each cost one cycle). No overlap between transactions.
- Boundary conditions:
  - in_valid while busy is ignored; the source must hold the state until in_ready.
  - out_ready held high before out_valid is harmless.
  - out_state is unchanged outside DONE-exit/RUN-completion updates.
  - rst asserted mid-RUN or in DONE aborts immediately; no output is produced.
  - Round index never wraps: i > 11 is unreachable.

Test Plan:
- Reset mid-RUN at cycle 5 of a 12-round job -> out_valid=0 and in_ready=1 immediately. A following job completes normally with correct latency.
- All-zero state, in_rounds=1, UNROLL=1 -> out_valid after 1 cycle. out_state x2 = 0x53FFFFFFFFFFFF90, x4 = 0.
- Same stimulus as the all-zero case, in_rounds=12 vs in_rounds=6 -> out_valid after 12 and 6 cycles respectively. Results match the golden software ASCON p12 and p6. out_err=0.
- in_rounds=0, then in_rounds=13; with UNROLL=2, also in_rounds=5 -> 12 rounds executed and out_err=1 for each. Results equal the p12 golden value.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_state stable, in_ready=0, and a new in_valid is not accepted. Release out_ready -> IDLE next cycle.
- UNROLL=3, 100 random states with R in {6,12} -> latencies of 2 and 4 cycles. Every result matches the golden model.

Source files
------------

// File: rtl/ascon_perm_core.sv
// Iterative ASCON permutation: UNROLL rounds per clock, round count chosen per job.
// Handshaked input and output; one transaction in flight at a time.
module ascon_perm_core #(
    parameter int UNROLL         = 1,
    parameter int DEFAULT_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] in_state,
    input  logic [3:0]   in_rounds,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] out_state,
    output logic         out_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e         fsm_q;
    logic [319:0] st_q;
    logic [319:0] out_state_q;
    logic [3:0]   idx_q;
    logic         err_q;
    logic         out_err_q;
    logic         out_valid_q;
    logic         in_ready_q;
    logic         busy_q;

    logic [319:0] rnd_d;
    logic         last_d;
    logic         legal_d;
    logic [3:0]   rounds_d;

    function automatic logic [63:0] ror(input logic [63:0] w, input int n);
        return (w >> n) | (w << (64 - n));
    endfunction

    function automatic logic [319:0] round_f(input logic [319:0] s,
                                             input logic [3:0]   idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2 = x2 ^ {56'd0, 4'hF - idx, idx};
        // bit-sliced 5-bit S-box across all 64 columns
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_comb begin : p_round
        logic [319:0] acc;
        acc = st_q;
        for (int u = 0; u < UNROLL; u++) begin
            acc = round_f(acc, idx_q + 4'(u));
        end
        rnd_d  = acc;
        last_d = (idx_q + 4'(UNROLL - 1)) == 4'd11;
    end

    always_comb begin
        legal_d  = (in_rounds != 4'd0) && (in_rounds <= 4'd12) &&
                   ((in_rounds % 4'(UNROLL)) == 4'd0);
        rounds_d = legal_d ? in_rounds : 4'(DEFAULT_ROUNDS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            out_state_q <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q       <= in_state;
                        idx_q      <= 4'd12 - rounds_d;
                        err_q      <= ~legal_d;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        fsm_q      <= RUN;
                    end
                end
                RUN: begin
                    st_q <= rnd_d;
                    if (last_d) begin
                        // index returns to 0 so it never walks past 11
                        idx_q       <= '0;
                        out_state_q <= rnd_d;
                        out_err_q   <= err_q;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        fsm_q       <= DONE;
                    end else begin
                        idx_q <= idx_q + 4'(UNROLL);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_err   = out_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Bench for ascon_perm_core: three instances (UNROLL 1,2,3) checked against
// a table-driven ASCON model through an expected-result queue.
module tb_ascon_perm_core;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    typedef struct {
        int           k;
        logic [319:0] st;
        logic         err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [2:0]   out_err;
    logic [2:0]   busy;
    logic [319:0] in_state;
    logic [3:0]   in_rounds;
    logic [319:0] out_state [3];

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_total;
    int   n_bad;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ascon_perm_core #(
            .UNROLL        (g + 1),
            .DEFAULT_ROUNDS(12)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_state (in_state),
            .in_rounds(in_rounds),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_state(out_state[g]),
            .out_err  (out_err[g]),
            .busy     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] got,
                       input logic [319:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
        logic [63:0] o;
        for (int b = 0; b < 64; b++) o[b] = w[(b + n) % 64];
        return o;
    endfunction

    function automatic logic [319:0] model(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  o;
        for (int j = 0; j < 5; j++) x[j] = s[319 - 64 * j -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[col];
                y[0][b] = o[4];
                y[1][b] = o[3];
                y[2][b] = o[2];
                y[3][b] = o[1];
                y[4][b] = o[0];
            end
            x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
            x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
            x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
            x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
            x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom())};
        return r;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && out_valid[k] && out_ready[k]) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 320'(k), 320'(99));
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_unit", 320'(k), 320'(mon_e.k));
                    chk("state", out_state[k], mon_e.st);
                    chk("err", 320'(out_err[k]), 320'(mon_e.err));
                end
            end
        end
    end

    // called at posedge+#1; returns at posedge+#1 with the unit back in IDLE
    task automatic run_job(input int k, input logic [319:0] st,
                           input logic [3:0] r, input int hold);
        logic         legal;
        logic [3:0]   eff;
        int           n;
        logic [319:0] held;
        exp_t         e;
        legal = (r >= 4'd1) && (r <= 4'd12) && ((int'(r) % (k + 1)) == 0);
        eff   = legal ? r : 4'd12;
        e.k   = k;
        e.st  = model(st, int'(eff));
        e.err = ~legal;
        sb_q.push_back(e);
        out_ready[k] = (hold == 0);
        in_state     = st;
        in_rounds    = r;
        in_valid[k]  = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("accept_timeout", 320'(n), 320'(0));
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        chk("busy_run", 320'(busy[k]), 320'(1));
        chk("rdy_run", 320'(in_ready[k]), 320'(0));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid[k] && n < 64);
        chk("latency", 320'(n), 320'(int'(eff) / (k + 1)));
        if (hold > 0) begin
            held        = out_state[k];
            in_state    = ~st;
            in_valid[k] = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                chk("bp_state", out_state[k], held);
                chk("bp_rdy", 320'(in_ready[k]), 320'(0));
                chk("bp_valid", 320'(out_valid[k]), 320'(1));
            end
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("exit_valid", 320'(out_valid[k]), 320'(0));
        chk("exit_rdy", 320'(in_ready[k]), 320'(1));
    endtask

    initial begin
        logic [319:0] s;
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        in_state  = '0;
        in_rounds = 4'd12;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rdy", 320'(in_ready[k]), 320'(1));
            chk("rst_valid", 320'(out_valid[k]), 320'(0));
            chk("rst_err", 320'(out_err[k]), 320'(0));
            chk("rst_busy", 320'(busy[k]), 320'(0));
            chk("rst_state", out_state[k], '0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_rdy", 320'(in_ready[0]), 320'(1));

        // abort a 12-round job mid-run; nothing may come out
        in_state    = rand320();
        in_rounds   = 4'd12;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_valid", 320'(out_valid[0]), 320'(0));
        chk("abort_rdy", 320'(in_ready[0]), 320'(1));
        chk("abort_busy", 320'(busy[0]), 320'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_job(0, rand320(), 4'd12, 0);

        run_job(0, '0, 4'd1, 0);
        chk("p1_x2", 320'(out_state[0][191:128]), 320'(64'h53FFFFFFFFFFFF90));
        chk("p1_x4", 320'(out_state[0][63:0]), 320'(0));
        run_job(0, '0, 4'd12, 0);
        run_job(0, '0, 4'd6, 0);

        run_job(0, '0, 4'd0, 0);
        run_job(0, '0, 4'd13, 0);
        run_job(1, '0, 4'd5, 0);
        run_job(1, '0, 4'd12, 0);
        run_job(1, rand320(), 4'd6, 0);
        run_job(1, rand320(), 4'd3, 0);
        run_job(2, '0, 4'd4, 0);

        run_job(0, rand320(), 4'd12, 20);

        for (int i = 0; i < 100; i++) begin
            s = rand320();
            run_job(2, s, ($urandom_range(0, 1) == 0) ? 4'd6 : 4'd12, 0);
        end

        chk("sb_left", 320'(sb_q.size()), 320'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
